// File: rtl/ds1302_slave_emu_if.sv
// Host-side bus of the DS1302 responder: CE/SCLK from the host, time file and
// write strobe back, plus the IO driver enable and FSM state for observation.
interface ds1302_slave_emu_if;
  // wr_pulse is a single-cycle strobe with no back-pressure: it is high for exactly
  // one sclk cycle per committed write, and bcd_time already holds the new value then.
  logic        ds1302_ce;
  logic        ds1302_sclk;
  logic [63:0] bcd_time;
  logic        wr_pulse;
  logic        dbg_io_oe;
  logic [2:0]  dbg_state;

  modport slave  (input ds1302_ce, ds1302_sclk,
                  output bcd_time, wr_pulse, dbg_io_oe, dbg_state);
  modport master (output ds1302_ce, ds1302_sclk,
                  input bcd_time, wr_pulse, dbg_io_oe, dbg_state);
endinterface

// File: rtl/ds1302_slave_emu.sv
// DS1302 device-side emulation: single-byte register read/write over CE/SCLK/IO,
// an 8-register BCD time file with write protect, and a sec/min/hour timekeeper.
module ds1302_slave_emu #(
  parameter int sys_clk_freq = 50_000_000,
  parameter bit tick_enable  = 1'b1
) (
  input  logic              sclk,
  input  logic              rst,
  ds1302_slave_emu_if.slave bus,
  inout  wire               ds1302_io
);
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_HOLD} state_e;

  localparam int PW = (sys_clk_freq > 1) ? $clog2(sys_clk_freq) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(sys_clk_freq - 1);

  state_e state_q, state_d;
  logic [1:0] ce_sync_q, sclk_sync_q, io_sync_q;
  logic ce_prev_q, sclk_prev_q;
  logic ce_s, sclk_s, io_s, ce_rise, sclk_rise, sclk_fall;
  logic [2:0] bit_cnt_q, idx_q;
  logic [6:0] cmd_q, wd_q;
  logic [7:0] cmd_full, wd_full, tx_q;
  logic last_bit, cmd_valid, oe_q, wr_pulse_q;
  logic cmd_shift, wd_shift, wr_commit, rd_latch, rd_start, rd_shift, rd_release;
  logic [7:0] sec_q, min_q, hour_q, date_q, mon_q, day_q, year_q;
  logic [7:0] sec_d, min_d, hour_d, date_d, mon_d, day_d, year_d;
  logic wp_q, wp_d, tick;
  logic [PW-1:0] presc_q;
  logic [8:0] sec_inc, min_inc;
  logic [5:0] hour_inc;

  assign ce_s      = ce_sync_q[1];
  assign sclk_s    = sclk_sync_q[1];
  assign io_s      = io_sync_q[1];
  assign ce_rise   = ce_s & ~ce_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cmd_full  = {io_s, cmd_q};
  assign wd_full   = {io_s, wd_q};
  assign last_bit  = (bit_cnt_q == 3'd7);
  // Burst (bits5:1 = 11111) and RAM (bit6 = 1) commands both fail this decode.
  assign cmd_valid = cmd_full[7] & ~cmd_full[6] & (cmd_full[5:4] == 2'b00);

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      ce_sync_q   <= '0;
      sclk_sync_q <= '0;
      io_sync_q   <= '0;
      ce_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      state_q     <= S_IDLE;
    end else begin
      ce_sync_q   <= {ce_sync_q[0], bus.ds1302_ce};
      sclk_sync_q <= {sclk_sync_q[0], bus.ds1302_sclk};
      io_sync_q   <= {io_sync_q[0], ds1302_io};
      ce_prev_q   <= ce_s;
      sclk_prev_q <= sclk_s;
      state_q     <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!ce_s) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:  if (ce_rise) state_d = S_CMD;
        S_CMD:   if (sclk_rise && last_bit)
                   state_d = !cmd_valid ? S_HOLD : (cmd_full[0] ? S_RDATA : S_WDATA);
        S_WDATA: if (sclk_rise && last_bit) state_d = S_HOLD;
        S_RDATA: if (rd_release) state_d = S_HOLD;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cmd_shift  = 1'b0;
    wd_shift   = 1'b0;
    wr_commit  = 1'b0;
    rd_latch   = 1'b0;
    rd_start   = 1'b0;
    rd_shift   = 1'b0;
    rd_release = 1'b0;
    if (ce_s) begin
      case (state_q)
        S_CMD: begin
          cmd_shift = sclk_rise;
          rd_latch  = sclk_rise & last_bit & cmd_valid & cmd_full[0];
        end
        S_WDATA: begin
          wd_shift  = sclk_rise;
          wr_commit = sclk_rise & last_bit & (~wp_q | (idx_q == 3'd7));
        end
        S_RDATA: begin
          rd_start   = sclk_fall & ~oe_q;
          rd_shift   = sclk_fall & oe_q & ~last_bit;
          rd_release = sclk_fall & oe_q & last_bit;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      idx_q      <= '0;
      cmd_q      <= '0;
      wd_q       <= '0;
      tx_q       <= '0;
      oe_q       <= 1'b0;
      wr_pulse_q <= 1'b0;
    end else begin
      wr_pulse_q <= wr_commit;
      if (!ce_s || state_q == S_IDLE) bit_cnt_q <= '0;
      else if (cmd_shift || wd_shift || rd_shift) bit_cnt_q <= bit_cnt_q + 3'd1;
      if (cmd_shift) cmd_q <= cmd_full[7:1];
      if (cmd_shift && last_bit) idx_q <= cmd_full[3:1];
      if (wd_shift) wd_q <= wd_full[7:1];
      // Snapshot at command completion so a tick mid-read cannot tear the byte.
      if (rd_latch) begin
        case (cmd_full[3:1])
          3'd0:    tx_q <= sec_q;
          3'd1:    tx_q <= min_q;
          3'd2:    tx_q <= hour_q;
          3'd3:    tx_q <= date_q;
          3'd4:    tx_q <= mon_q;
          3'd5:    tx_q <= day_q;
          3'd6:    tx_q <= year_q;
          default: tx_q <= {wp_q, 7'b0};
        endcase
      end else if (rd_shift) tx_q <= {1'b0, tx_q[7:1]};
      if (!ce_s || rd_release) oe_q <= 1'b0;
      else if (rd_start) oe_q <= 1'b1;
    end
  end

  function automatic logic [8:0] bcd_inc59(input logic [7:0] v);
    if (v == 8'h59) return {1'b1, 8'h00};
    else if (v[3:0] == 4'h9) return {1'b0, v[7:4] + 4'h1, 4'h0};
    else return {1'b0, v + 8'h01};
  endfunction

  assign tick     = tick_enable && (presc_q == PRESC_MAX) && !sec_q[7];
  assign sec_inc  = bcd_inc59(sec_q);
  assign min_inc  = bcd_inc59(min_q);
  assign hour_inc = (hour_q[5:0] == 6'h23) ? 6'h00 :
                    (hour_q[3:0] == 4'h9) ? {hour_q[5:4] + 2'd1, 4'h0} : hour_q[5:0] + 6'd1;

  // Tick is applied first; a same-cycle write then overrides only its own register.
  always_comb begin
    sec_d = sec_q; min_d = min_q; hour_d = hour_q; date_d = date_q;
    mon_d = mon_q; day_d = day_q; year_d = year_q; wp_d = wp_q;
    if (tick) begin
      sec_d = sec_inc[7:0];
      if (sec_inc[8]) begin
        min_d = min_inc[7:0];
        if (min_inc[8]) hour_d = {hour_q[7:6], hour_inc};
      end
    end
    if (wr_commit) begin
      case (idx_q)
        3'd0:    sec_d  = wd_full;
        3'd1:    min_d  = wd_full;
        3'd2:    hour_d = wd_full;
        3'd3:    date_d = wd_full;
        3'd4:    mon_d  = wd_full;
        3'd5:    day_d  = wd_full;
        3'd6:    year_d = wd_full;
        default: wp_d   = wd_full[7];
      endcase
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      sec_q <= 8'h00; min_q <= 8'h00; hour_q <= 8'h00; date_q <= 8'h01;
      mon_q <= 8'h01; day_q <= 8'h01; year_q <= 8'h00; wp_q   <= 1'b1;
      presc_q <= '0;
    end else begin
      sec_q <= sec_d; min_q <= min_d; hour_q <= hour_d; date_q <= date_d;
      mon_q <= mon_d; day_q <= day_d; year_q <= year_d; wp_q   <= wp_d;
      if ((wr_commit && idx_q == 3'd0) || presc_q == PRESC_MAX) presc_q <= '0;
      else presc_q <= presc_q + PW'(1);
    end
  end

  assign ds1302_io     = oe_q ? tx_q[0] : 1'bz;
  assign bus.bcd_time  = {wp_q, 7'b0, year_q, day_q, mon_q, date_q, hour_q, min_q, sec_q};
  assign bus.wr_pulse  = wr_pulse_q;
  assign bus.dbg_io_oe = oe_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_ds1302_slave_emu.sv
// Bench for ds1302_slave_emu: a bit-banged DS1302 host drives directed transactions;
// a negedge monitor checks every write strobe and read byte against queued expectations.
module tb_ds1302_slave_emu;
  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst;
  logic host_oe, host_bit;
  wire  ds1302_io;
  int   checks = 0, errors = 0, cyc = 0, last_wr_cyc = 0;
  logic [10:0] wr_exp_q[$];
  logic [7:0]  rd_exp_q[$];
  logic [7:0]  rd_byte;
  logic        rd_strobe = 1'b0;
  logic        watch_oe = 1'b0, oe_seen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ds1302_slave_emu_if bus();
  assign ds1302_io = host_oe ? host_bit : 1'bz;

  ds1302_slave_emu #(.sys_clk_freq(100), .tick_enable(1'b1)) u_dut (
    .sclk(clk), .rst(rst), .bus(bus), .ds1302_io(ds1302_io));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_pulse) begin
        logic [10:0] e;
        last_wr_cyc = cyc;
        if (wr_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got wr_pulse with bcd_time %h, required none", bus.bcd_time);
        end else begin
          e = wr_exp_q.pop_front();
          check($sformatf("wr_reg%0d", e[10:8]), 64'(bus.bcd_time[e[10:8]*8 +: 8]), 64'(e[7:0]));
        end
      end
      if (rd_strobe) begin
        if (rd_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got byte %h, required none", rd_byte);
        end else check("rd_byte", 64'(rd_byte), 64'(rd_exp_q.pop_front()));
      end
      if (watch_oe && bus.dbg_io_oe) oe_seen = 1'b1;
    end
  end

  task automatic hwait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_xfer();
    bus.ds1302_ce = 1'b1;
    hwait(HALF);
  endtask

  task automatic end_xfer();
    host_oe = 1'b0;
    bus.ds1302_ce = 1'b0;
    hwait(HALF);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      host_oe = 1'b1;
      host_bit = b[i];
      hwait(HALF);
      bus.ds1302_sclk = 1'b1;
      hwait(HALF);
      bus.ds1302_sclk = 1'b0;
    end
  endtask

  task automatic host_read(input logic [7:0] cmd, input bit report);
    logic [7:0] got;
    got = '0;
    start_xfer();
    send_bits(cmd, 8);
    host_oe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hwait(HALF);
      got[i] = ds1302_io;
      bus.ds1302_sclk = 1'b1;
      hwait(HALF);
      bus.ds1302_sclk = 1'b0;
    end
    if (report) begin
      rd_byte = got;
      @(posedge clk);
      rd_strobe = 1'b1;
      @(posedge clk);
      rd_strobe = 1'b0;
    end
    end_xfer();
  endtask

  task automatic do_read(input logic [7:0] cmd, input logic [7:0] exp);
    rd_exp_q.push_back(exp);
    host_read(cmd, 1'b1);
  endtask

  task automatic do_write(input logic [7:0] cmd, input logic [7:0] data,
                          input bit commits, input logic [7:0] stored);
    if (commits) wr_exp_q.push_back({cmd[3:1], stored});
    start_xfer();
    send_bits(cmd, 8);
    send_bits(data, 8);
    end_xfer();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no end of run, required finish before 50000 cycles");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    host_oe = 1'b0;
    host_bit = 1'b0;
    bus.ds1302_ce = 1'b0;
    bus.ds1302_sclk = 1'b0;
    hwait(4);
    check("rst_bcd_time", bus.bcd_time, 64'h8000_0101_0100_0000);
    check("rst_wr_pulse", 64'(bus.wr_pulse), 64'h0);
    check("rst_io_oe", 64'(bus.dbg_io_oe), 64'h0);
    check("rst_state", 64'(bus.dbg_state), 64'h0);
    rst = 1'b0;
    hwait(1);

    // Seconds read first, before the first tick at 100 cycles.
    do_read(8'h81, 8'h00);
    do_read(8'h8F, 8'h80);

    do_write(8'h8E, 8'h00, 1'b1, 8'h00);
    do_write(8'h80, 8'h45, 1'b1, 8'h45);
    check("wp_cleared", 64'(bus.bcd_time[63:56]), 64'h00);
    do_read(8'h81, 8'h45);

    // Halt the clock (CH), then re-enable write protect.
    do_write(8'h80, 8'h80, 1'b1, 8'h80);
    do_write(8'h8E, 8'h80, 1'b1, 8'h80);
    do_write(8'h82, 8'h30, 1'b0, 8'h00);
    check("wp_blocks_minute", 64'(bus.bcd_time[15:8]), 64'h00);
    do_write(8'h8E, 8'h00, 1'b1, 8'h00);

    // Partial write aborted by CE after 5 data bits.
    start_xfer();
    send_bits(8'h84, 8);
    send_bits(8'h12, 5);
    end_xfer();
    check("abort_hour", 64'(bus.bcd_time[23:16]), 64'h00);
    check("abort_io_oe", 64'(bus.dbg_io_oe), 64'h0);
    check("abort_state", 64'(bus.dbg_state), 64'h0);
    do_write(8'h84, 8'h12, 1'b1, 8'h12);
    do_read(8'h85, 8'h12);

    // Invalid commands: driver must stay off, time file unchanged.
    oe_seen = 1'b0;
    watch_oe = 1'b1;
    host_read(8'hC1, 1'b0);
    host_read(8'hBF, 1'b0);
    watch_oe = 1'b0;
    check("invalid_oe_seen", 64'(oe_seen), 64'h0);
    check("invalid_bcd_time", bus.bcd_time, 64'h0000_0101_0112_0080);

    // Rollover 23:59:59 -> 00:00:00 exactly 100 cycles after the seconds write.
    do_write(8'h84, 8'h23, 1'b1, 8'h23);
    do_write(8'h82, 8'h59, 1'b1, 8'h59);
    do_write(8'h80, 8'h59, 1'b1, 8'h59);
    for (int k = 0; k < 400 && cyc < last_wr_cyc + 99; k++) @(negedge clk);
    check("pre_rollover", bus.bcd_time, 64'h0000_0101_0123_5959);
    @(negedge clk);
    check("rollover", bus.bcd_time, 64'h0000_0101_0100_0000);

    do_write(8'h80, 8'h80, 1'b1, 8'h80);
    hwait(300);
    check("ch_halted", bus.bcd_time, 64'h0000_0101_0100_0080);

    hwait(20);
    check("wr_exp_drained", 64'(wr_exp_q.size()), 64'h0);
    check("rd_exp_drained", 64'(rd_exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ds1302_slave_emu.md
# ds1302_slave_emu

Synthesizable DS1302 responder: the device end of the 3-wire CE/SCLK/IO serial interface. It decodes single-byte clock-register read and write commands from a DS1302 host controller and serves an 8-register BCD time file with write protect and a seconds/minutes/hours timekeeper. It stands in for the physical RTC in simulation, in FPGA loopback builds, and on boards without the chip.

## Interface
- `sys_clk_freq`, default 50_000_000: system clock frequency in Hz; sets the 1 s tick prescaler.
- `tick_enable`, default 1: 1 = timekeeper runs; 0 = registers change only by writes.
- `sclk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ds1302_ce`  in  1  chip enable from the host.
- `ds1302_sclk`  in  1  serial clock from the host.
- `ds1302_io`  inout  1  serial data; driven only during read data phase, otherwise high-Z.
- `bcd_time`  out  64  live registers `{wp, year, day, month, date, hour, minute, second}`.
- `wr_pulse`  out  1  one-cycle pulse per committed register write.

## Operation
- `ds1302_ce`, `ds1302_sclk` and `ds1302_io` (input side) each pass through a 2-flop synchronizer. Edge detection works on the synchronized SCLK.
- The host SCLK period must be at least 8 `sclk` cycles.
- Command byte: LSB first.
  - bit0 = 1 means read.
  - bits3:1 = register index: 0 sec, 1 min, 2 hour, 3 date, 4 month, 5 day, 6 year, 7 wp.
  - Valid only when bit7 = 1, bit6 = 0 and bits5:4 = 00. Burst (0xBE/0xBF) and RAM commands are invalid.
- FSM states: IDLE, CMD, WDATA, RDATA, HOLD.
  - IDLE → CMD when synchronized CE rises.
  - CMD: shift in one bit on each SCLK rising edge. After the 8th bit:
    - invalid command → HOLD;
    - write → WDATA;
    - read → latch the selected register into the TX shift register, then RDATA.
  - WDATA: shift in 8 bits on rising edges. On the 8th bit, commit if wp[7] = 0 or the index is 7, and pulse `wr_pulse`. Then go to HOLD.
  - RDATA: enable the output driver from the falling edge that follows the 8th command rising edge. That edge presents data bit0; each later falling edge presents the next bit. The driver releases on the falling edge after bit7 is presented. Then go to HOLD.
  - HOLD: ignore SCLK until CE falls.
- CE low in any state → IDLE on the next cycle. The driver releases immediately, bit counters clear, and a partial write is discarded.
- Only wp bit7 is stored; wp bits6:0 read back 0. All other registers store 8 bits as written, with no BCD validity check.
- Timekeeper: the prescaler counts `sys_clk_freq` cycles. A tick occurs when `tick_enable` = 1 and second[7] (CH) = 0.
  - second BCD 00..59 wraps and carries into minute.
  - minute 00..59 wraps and carries into hour.
  - hour[5:0] 00..23 wraps; hour bit7 and bit6 are held unchanged.
  - date, month, day and year never advance.
- A write to the seconds register clears the prescaler. If a write and a tick land in the same cycle, the write wins for the written register; carries into other registers still apply.

## Timing
- Reset values:
  - second 0x00, minute 0x00, hour 0x00, date 0x01, month 0x01, day 0x01, year 0x00, wp 0x80;
  - `wr_pulse` 0, IO driver disabled, FSM in IDLE, prescaler 0.
- Input latency: 2 `sclk` cycles of synchronizer plus 1 cycle of edge detect.
  - Write commit and `wr_pulse` occur 3 cycles after the raw 8th data SCLK rise.
  - `bcd_time` updates in the same cycle as `wr_pulse`.
- Read bit valid on `ds1302_io` no later than 3 cycles after the raw SCLK fall. The host samples on the rising edge, at least 4 cycles later.
- Read data is a snapshot taken at command completion; a tick during the data phase does not alter bits already latched.
- Tick: `bcd_time` updates one cycle after the prescaler reaches `sys_clk_freq`-1.

## Test plan
- After reset, host reads cmd 0x8F → IO returns 0x80 LSB first (bit7 = 1 only). Cmd 0x81 → 0x00.
- Write 0x8E←0x00, then 0x80←0x45 → `bcd_time[7:0]` = 0x45, `bcd_time[63:56]` = 0x00, two `wr_pulse`. Read back 0x81 → 0x45.
- With wp = 0x80, write 0x82←0x30 → minute stays 0x00, no `wr_pulse`. Writing 0x8E←0x00 is still accepted.
- `sys_clk_freq` = 100, time set to 23:59:59 (hour 0x23, minute 0x59, second 0x59) → 100 cycles later 00:00:00, date unchanged at 0x01. Writing second 0x80 (CH) → no further ticks.
- CE dropped after 5 data bits of write 0x84←0x12 → hour unchanged, no `wr_pulse`, IO high-Z, next transaction decodes normally.
- Invalid commands 0xC1 and 0xBF → IO never driven, no register changes.
